// File: rtl/fifo_rd_stream_if.sv
// Read-side bus bundle for fifo_rd_stream.
// It carries two groups of signals:
//   - the FIFO read port: fifo_rempty, fifo_ren, fifo_dout
//   - the output stream:  m_valid, m_ready, m_data, m_last
// Modports:
//   master - the drain stage. It drives fifo_ren and the stream outputs.
//   slave  - the FIFO plus the downstream consumer, seen as one peer.
interface fifo_rd_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             fifo_rempty;
    logic             fifo_ren;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_rempty,
        input  fifo_dout,
        input  m_ready,
        output fifo_ren,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_rempty,
        output fifo_dout,
        output m_ready,
        input  fifo_ren,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for async_fifo (rclk domain).
// It issues ren against rempty and absorbs the one-cycle registered RAM read
// latency in a 3-entry prefetch buffer. The data leaves as a valid/ready
// stream, with m_last marking the final beat of every PKT_LEN-beat packet.
// Ports:
//   clk    read-side clock (FIFO rclk)
//   rst_n  asynchronous active-low reset
//   en     permits new FIFO reads; words already buffered or in flight
//          still drain while it is low
//   busy   words are buffered or in flight
//   bus    FIFO read port plus the output stream (master modport)
module fifo_rd_stream #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   busy,
    fifo_rd_stream_if.master       bus
);

    localparam int unsigned DEPTH     = 3;
    localparam int unsigned BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned LAST_BEAT = PKT_LEN - 1;

    logic              run;
    logic [1:0]        cnt;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [2:0]        occ_c;
    logic              ren_c;
    logic              pop_c;
    logic [1:0]        cnt_nxt;
    logic [1:0]        wr_idx;
    logic [BEAT_W-1:0] beat_nxt;
    logic [WIDTH-1:0]  mem_nxt [DEPTH];

    // Count buffered words plus the in-flight read, so ren can never
    // overcommit the buffer.
    assign occ_c = {1'b0, cnt} + {2'b00, inflight};
    assign ren_c = run & en & ~bus.fifo_rempty & (occ_c < 3'(DEPTH));
    assign pop_c = (cnt != 2'd0) & bus.m_ready;

    // Occupancy update: the capture of the in-flight word and the pop can
    // cancel each other out.
    always_comb begin
        cnt_nxt = cnt;
        unique case ({inflight, pop_c})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Shift-down buffer, so the head always sits in mem[0].
    // On a simultaneous pop, the new word lands one slot lower. cnt is at
    // least 1 whenever a pop occurs, so cnt - 1 cannot underflow.
    always_comb begin
        wr_idx = pop_c ? (cnt - 2'd1) : cnt;
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop_c) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (inflight && (wr_idx == 2'(i))) begin
                mem_nxt[i] = bus.fifo_dout;
            end
        end
    end

    // Beat position inside the current packet; advances only on a handshake.
    always_comb begin
        beat_nxt = beat;
        if (pop_c) begin
            beat_nxt = (beat == BEAT_W'(LAST_BEAT)) ? '0 : beat + BEAT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            cnt      <= 2'd0;
            inflight <= 1'b0;
            beat     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            run      <= 1'b1;
            cnt      <= cnt_nxt;
            inflight <= ren_c;
            beat     <= beat_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

    assign bus.fifo_ren = ren_c;
    assign bus.m_valid  = (cnt != 2'd0);
    assign bus.m_data   = mem[0];
    assign bus.m_last   = (cnt != 2'd0) & (beat == BEAT_W'(LAST_BEAT));
    assign busy         = (cnt != 2'd0) | inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PKT_LEN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic busy;
    logic fifo_flush = 1'b0;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] pend[$];
    logic [WIDTH-1:0] expq[$];

    fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

    fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .busy  (busy),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (required finish before timeout)");
        $fatal(1);
    end

    // Behavioural FIFO: a queue whose registered read data appears one cycle after ren.
    always @(posedge clk) begin
        logic [WIDTH-1:0] tmp;
        if (fifo_flush) begin
            q.delete();
            pend.delete();
            bus.fifo_dout   <= '0;
            bus.fifo_rempty <= 1'b1;
        end else begin
            if (bus.fifo_ren) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_underflow: ren=1 with FIFO empty (required ren=0)");
                end else begin
                    tmp = q.pop_front();
                    bus.fifo_dout <= tmp;
                end
            end
            while (pend.size() != 0) q.push_back(pend.pop_front());
            bus.fifo_rempty <= (q.size() == 0);
        end
    end

    // Scoreboard monitor: checks order, packet position, hold-while-stalled and occupancy.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        int               occ;
        if (fifo_flush) begin
            expq.delete();
            pops = 0;
        end
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            occ = int'(dut.cnt) + int'(dut.inflight);
            checks++;
            assert (occ <= 3) else begin
                errors++;
                $display("FAIL occupancy: cnt+inflight=%0d (required <=3)", occ);
            end
            if (prev_stall) begin
                checks++;
                if (!bus.m_valid || bus.m_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%0h (required valid=1 data=%0h)",
                             bus.m_valid, bus.m_data, prev_data);
                end
            end
            if (!bus.m_valid) begin
                checks++;
                if (bus.m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL last_without_valid: m_last=%0b (required 0)", bus.m_last);
                end
            end else begin
                exp_l = ((pops % PKT_LEN) == (PKT_LEN - 1));
                checks++;
                if (bus.m_last !== exp_l) begin
                    errors++;
                    $display("FAIL m_last: beat %0d got %0b (required %0b)", pops % PKT_LEN, bus.m_last, exp_l);
                end
                if (bus.m_ready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word: got %0h (required no word)", bus.m_data);
                    end else begin
                        exp_d = expq.pop_front();
                        if (bus.m_data !== exp_d) begin
                            errors++;
                            $display("FAIL m_data: word %0d got %0h (required %0h)", pops, bus.m_data, exp_d);
                        end
                    end
                    pops++;
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (required %0d)", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        pend.push_back(w);
        expq.push_back(w);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s: %0d words outstanding busy=%0b (required 0 and 0)", name, expq.size(), busy);
        end
    endtask

    initial begin
        int c, first_ren, first_val, last_hs, hs, rens, first_last;
        logic [WIDTH-1:0] head;
        logic found;

        // 1/2: reset hold, release timing, latency and full-rate 40-word stream.
        bus.m_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 40; i++) push_word(WIDTH'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ren", 32'(bus.fifo_ren), 0);
        check("rst_valid", 32'(bus.m_valid), 0);
        check("rst_data", 32'(bus.m_data), 0);
        check("rst_last", 32'(bus.m_last), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("ren_first_cycle", 32'(bus.fifo_ren), 0);
        c = 0; first_ren = -1; first_val = -1; last_hs = -1; hs = 0;
        while (hs < 40 && c < 200) begin
            c++;
            @(negedge clk);
            if (bus.fifo_ren && first_ren < 0) first_ren = c;
            if (bus.m_valid && first_val < 0) first_val = c;
            if (bus.m_valid && bus.m_ready) begin hs++; last_hs = c; end
        end
        check("ren_second_cycle", 32'(first_ren), 1);
        check("latency", 32'(first_val - first_ren), 2);
        check("full_rate", 32'(last_hs - first_val), 39);
        wait_drain(50, "drain_t2");

        // 3: backpressure with plenty of FIFO content.
        @(posedge clk); #1 bus.m_ready = 1'b0;
        head = WIDTH'($urandom);
        push_word(head);
        for (int i = 0; i < 19; i++) push_word(WIDTH'($urandom));
        rens = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.fifo_ren) rens++;
        end
        check("bp_ren_pulses", 32'(rens), 3);
        check("bp_cnt", 32'(dut.cnt), 3);
        check("bp_valid", 32'(bus.m_valid), 1);
        check("bp_head", 32'(bus.m_data), 32'(head));
        @(posedge clk); #1 bus.m_ready = 1'b1;
        wait_drain(100, "drain_t3");

        // 4: random ready and random FIFO fill, 10k words.
        for (int sent = 0; sent < 10000; ) begin
            @(posedge clk); #1;
            bus.m_ready = 1'($urandom % 2);
            if (($urandom % 2) == 0) begin
                push_word(WIDTH'($urandom));
                sent++;
            end
        end
        @(posedge clk); #1 bus.m_ready = 1'b1;
        wait_drain(20000, "drain_t4");

        // 5: en drop with one buffered word and one in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) push_word(WIDTH'($urandom));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dut.cnt == 2'd1 && dut.inflight && bus.m_valid && bus.m_ready) found = 1'b1;
        end
        check("en_drop_setup", 32'(found), 1);
        en = 1'b0;
        hs = (bus.m_valid && bus.m_ready) ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) hs++;
        end
        check("en_drop_words", 32'(hs), 2);
        check("en_drop_valid", 32'(bus.m_valid), 0);
        check("en_drop_busy", 32'(busy), 0);
        @(posedge clk); #1 en = 1'b1;
        wait_drain(200, "drain_t5");

        // 6: asynchronous reset at beat 5 of a packet.
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) push_word(WIDTH'($urandom));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if ((pops % PKT_LEN) == 5 && bus.m_valid) found = 1'b1;
        end
        check("beat5_setup", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ren", 32'(bus.fifo_ren), 0);
        check("arst_valid", 32'(bus.m_valid), 0);
        check("arst_data", 32'(bus.m_data), 0);
        check("arst_last", 32'(bus.m_last), 0);
        check("arst_busy", 32'(busy), 0);
        fifo_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1 fifo_flush = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) push_word(WIDTH'($urandom));
        hs = 0; first_last = -1; c = 0;
        while (hs < 40 && c < 300) begin
            c++;
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) begin
                hs++;
                if (bus.m_last && first_last < 0) first_last = hs;
            end
        end
        check("post_reset_first_last", 32'(first_last), 16);
        wait_drain(200, "drain_t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
